eth_mem_fifo_ctrl: RTL and testbench
====================================

Name: eth_mem_fifo_ctrl

Overview:
- Ready/valid FIFO control stage that owns a bsg_mem_1r1w_sync_wrapper instance's ports and drives its write and read sides.
- Enqueue side accepts ethernet frame words; dequeue side presents them with full throughput.
- A one-entry output stage with bypass hides the memory's 1-cycle synchronous read latency.
- Sits directly upstream of the packet buffer memory in the ethernet controller and consumes the memory's r_data_o.

Parameters:
width_p, none (must be set), data word width in bits; matches the memory's width_p
els_p, none (must be set), memory depth; must be >= 2; need not be a power of two
addr_width_lp, `BSG_SAFE_CLOG2(els_p), memory address width (derived)
count_width_lp, `BSG_SAFE_CLOG2(els_p+2), width of count_o (derived)

Ports:
clk_i  in  1  clock; all state updates on its rising edge
reset_i  in  1  asynchronous, active-low reset (0 = in reset)
v_i  in  1  enqueue valid
data_i  in  width_p  enqueue data
ready_o  out  1  enqueue ready; a transfer occurs when v_i & ready_o
v_o  out  1  dequeue valid
data_o  out  width_p  dequeue data
yumi_i  in  1  dequeue accept; legal only when v_o=1
count_o  out  count_width_lp  total words held (memory + output stage)
w_v_o  out  1  to memory w_v_i
w_addr_o  out  addr_width_lp  to memory w_addr_i
w_data_o  out  width_p  to memory w_data_i
r_v_o  out  1  to memory r_v_i
r_addr_o  out  addr_width_lp  to memory r_addr_i
r_data_i  in  width_p  from memory r_data_o; valid the cycle after r_v_o=1

Behaviour:
- State:
  - wptr_r, rptr_r: 0..els_p-1; each increments by 1 and wraps from els_p-1 to 0 (explicit compare, no power-of-two masking).
  - mem_cnt_r: 0..els_p, counts words written to memory and not yet read.
  - rd_pend_r: a read was issued last cycle.
  - out_v_r, out_data_r: the output holding register.
- Invariant: rd_pend_r & out_v_r is never 1. Output-stage occupancy occ = rd_pend_r | out_v_r.
- While reset_i=0, all state is 0. ready_o, v_o, w_v_o and r_v_o are 0 combinationally during reset.
- Enqueue:
  - ready_o = (mem_cnt_r < els_p).
  - w_v_o = v_i & ready_o; w_addr_o = wptr_r; w_data_o = data_i.
  - wptr_r advances on w_v_o. v_i while ready_o=0 is ignored and writes nothing.
- Read issue: r_v_o = (mem_cnt_r != 0) & (~occ | yumi_i); r_addr_o = rptr_r. rptr_r advances on r_v_o.
- No same-cycle read/write collision: a word written in cycle N becomes visible in mem_cnt_r at N+1, so it can be read at N+1 at the earliest. A same-address read and write in one cycle is therefore impossible.
- mem_cnt_r next value = mem_cnt_r + w_v_o - r_v_o. Simultaneous write and read leaves it unchanged.
- Dequeue:
  - v_o = out_v_r | rd_pend_r.
  - data_o = out_v_r ? out_data_r : r_data_i (bypass of the memory output).
- Output stage next-state, evaluated in priority order:
  - if r_v_o: rd_pend_r<=1, out_v_r<=0.
  - else if rd_pend_r & ~yumi_i: out_v_r<=1, out_data_r<=r_data_i, rd_pend_r<=0.
  - else if yumi_i: out_v_r<=0, rd_pend_r<=0.
  - else hold.
- Full-throughput steady state: one enqueue and one dequeue per cycle.
- Latency from enqueue (cycle 0) to v_o=1 is 2 cycles: the write at 0, the read issued at 1, v_o with bypassed data at 2.
- Capacity is els_p+1 words: els_p in memory plus 1 in the output stage. ready_o deasserts only on a full memory.
- count_o = mem_cnt_r + occ.
- Asserted (simulation only): yumi_i=1 while v_o=0 is illegal; the invariant above holds.
- An async reset mid-stream discards all contents, including an in-flight read. r_data_i is ignored after reset is released.

Test Plan:
- Reset with els_p=4: hold reset_i=0, drive v_i=1 -> ready_o=0, v_o=0, w_v_o=0, r_v_o=0, count_o=0.
- Single word: enqueue 0xA5 at cycle 0 with yumi_i=0 -> w_v_o=1 at addr 0 in cycle 0; r_v_o=1 at addr 0 in cycle 1; v_o=1 with data_o=0xA5 from cycle 2 on, captured into out_data_r; count_o=1.
- Fill with els_p=4, no dequeue: enqueue 1..6 -> 1 lands in the output stage; 2..5 fill the memory; ready_o=0 after the 5th accepted word; word 6 is not written; count_o=5.
- Streaming: continuous v_i and yumi_i, words 0..19 with els_p=3 -> after 2-cycle fill, one word per cycle in order; pointers wrap 2->0; count_o stays at 2.
- Backpressure during bypass: yumi_i=0 in the cycle rd_pend_r=1 -> word captured in out_data_r; data_o is stable until yumi_i; no loss or duplication.
- Mid-operation reset: drop reset_i while count_o=3 and a read is pending -> all outputs go to 0 immediately; after release, enqueue 0x11 -> dequeued 0x11 only.

Source files
------------

// File: rtl/eth_mem_fifo_ctrl.sv
// Ready/valid FIFO controller for an external 1r1w synchronous memory.
// A one-entry output stage with bypass hides the memory's one-cycle read latency.
module eth_mem_fifo_ctrl #(
  parameter int width_p        = 8,
  parameter int els_p          = 4,
  parameter int addr_width_lp  = (els_p <= 1) ? 1 : $clog2(els_p),
  parameter int count_width_lp = $clog2(els_p + 2)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o,
  output logic                      w_v_o,
  output logic [addr_width_lp-1:0]  w_addr_o,
  output logic [width_p-1:0]        w_data_o,
  output logic                      r_v_o,
  output logic [addr_width_lp-1:0]  r_addr_o,
  input  logic [width_p-1:0]        r_data_i
);

  localparam logic [addr_width_lp-1:0]  addr_last = addr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] mem_full  = count_width_lp'(els_p);

  logic [addr_width_lp-1:0]  wptr_r, rptr_r;
  logic [count_width_lp-1:0] mem_cnt_r;
  logic                      rd_pend_r;
  logic                      out_v_r;
  logic [width_p-1:0]        out_data_r;
  logic                      occ;

  // Handshakes: enqueue transfers when v_i & ready_o; dequeue transfers when
  // yumi_i is high, and yumi_i may only be raised while v_o is high.
  assign occ      = rd_pend_r | out_v_r;
  assign ready_o  = reset_i & (mem_cnt_r < mem_full);
  assign w_v_o    = reset_i & v_i & ready_o;
  assign w_addr_o = wptr_r;
  assign w_data_o = data_i;

  // A word written this cycle is only counted next cycle, so a read never
  // targets the address being written in the same cycle.
  assign r_v_o    = reset_i & (mem_cnt_r != '0) & (~occ | yumi_i);
  assign r_addr_o = rptr_r;

  assign v_o      = reset_i & (out_v_r | rd_pend_r);
  assign data_o   = out_v_r ? out_data_r : r_data_i;
  assign count_o  = mem_cnt_r + count_width_lp'(occ);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      mem_cnt_r <= '0;
    end else begin
      if (w_v_o) wptr_r <= (wptr_r == addr_last) ? '0 : wptr_r + addr_width_lp'(1);
      if (r_v_o) rptr_r <= (rptr_r == addr_last) ? '0 : rptr_r + addr_width_lp'(1);
      mem_cnt_r <= mem_cnt_r + count_width_lp'(w_v_o) - count_width_lp'(r_v_o);
    end
  end

  // Output stage: a pending read either bypasses straight out or, if not
  // taken, is parked in out_data_r because r_data_i is only valid for one cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_pend_r  <= 1'b0;
      out_v_r    <= 1'b0;
      out_data_r <= '0;
    end else if (r_v_o) begin
      rd_pend_r <= 1'b1;
      out_v_r   <= 1'b0;
    end else if (rd_pend_r & ~yumi_i) begin
      out_v_r    <= 1'b1;
      out_data_r <= r_data_i;
      rd_pend_r  <= 1'b0;
    end else if (yumi_i) begin
      out_v_r   <= 1'b0;
      rd_pend_r <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      assert (!(yumi_i && !v_o));
      assert (!(rd_pend_r && out_v_r));
    end
  end
`endif

endmodule

// File: tb/tb_eth_mem_fifo_ctrl.sv
// Directed bench for eth_mem_fifo_ctrl: a 4-deep instance (a_) and a 3-deep
// instance (b_), each wired to a behavioural 1r1w synchronous memory.
module tb_eth_mem_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Instance a: els_p = 4
  logic       a_v_i, a_ready, a_v_o, a_yumi, a_w_v, a_r_v;
  logic [7:0] a_data_i, a_data_o, a_w_data, a_r_data;
  logic [2:0] a_count;
  logic [1:0] a_w_addr, a_r_addr;
  logic [7:0] a_mem [4];

  eth_mem_fifo_ctrl #(.width_p(8), .els_p(4)) dut_a (
    .clk_i(clk), .reset_i(rst_n), .v_i(a_v_i), .data_i(a_data_i),
    .ready_o(a_ready), .v_o(a_v_o), .data_o(a_data_o), .yumi_i(a_yumi),
    .count_o(a_count), .w_v_o(a_w_v), .w_addr_o(a_w_addr), .w_data_o(a_w_data),
    .r_v_o(a_r_v), .r_addr_o(a_r_addr), .r_data_i(a_r_data)
  );

  // Read data is only valid the cycle after a read; otherwise it is garbage.
  always @(posedge clk) begin
    if (a_w_v) a_mem[a_w_addr] <= a_w_data;
    a_r_data <= a_r_v ? a_mem[a_r_addr] : 8'hEE;
  end

  // Instance b: els_p = 3
  logic       b_v_i, b_ready, b_v_o, b_yumi, b_w_v, b_r_v;
  logic [7:0] b_data_i, b_data_o, b_w_data, b_r_data;
  logic [2:0] b_count;
  logic [1:0] b_w_addr, b_r_addr;
  logic [7:0] b_mem [4];

  eth_mem_fifo_ctrl #(.width_p(8), .els_p(3)) dut_b (
    .clk_i(clk), .reset_i(rst_n), .v_i(b_v_i), .data_i(b_data_i),
    .ready_o(b_ready), .v_o(b_v_o), .data_o(b_data_o), .yumi_i(b_yumi),
    .count_o(b_count), .w_v_o(b_w_v), .w_addr_o(b_w_addr), .w_data_o(b_w_data),
    .r_v_o(b_r_v), .r_addr_o(b_r_addr), .r_data_i(b_r_data)
  );

  always @(posedge clk) begin
    if (b_w_v) b_mem[b_w_addr] <= b_w_data;
    b_r_data <= b_r_v ? b_mem[b_r_addr] : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, wp, rp;
    logic [7:0] exp_w;
    rst_n = 1'b0;
    a_v_i = 1'b0; a_data_i = '0; a_yumi = 1'b0;
    b_v_i = 1'b0; b_data_i = '0; b_yumi = 1'b0;

    // Reset: v_i asserted must not leak through
    a_v_i = 1'b1; a_data_i = 8'h77;
    repeat (2) tick();
    check("rst_ready", a_ready, 0);
    check("rst_v_o",   a_v_o,   0);
    check("rst_w_v",   a_w_v,   0);
    check("rst_r_v",   a_r_v,   0);
    check("rst_count", a_count, 0);
    a_v_i = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single word, held without dequeue
    a_v_i = 1'b1; a_data_i = 8'hA5; #1;
    check("sw_ready",  a_ready,  1);
    check("sw_w_v",    a_w_v,    1);
    check("sw_w_addr", a_w_addr, 0);
    check("sw_w_data", a_w_data, 8'hA5);
    tick(); a_v_i = 1'b0; #1;
    check("sw_r_v",    a_r_v,    1);
    check("sw_r_addr", a_r_addr, 0);
    check("sw_v_o_c1", a_v_o,    0);
    check("sw_cnt_c1", a_count,  1);
    tick();
    check("sw_v_o_c2",  a_v_o,    1);
    check("sw_data_c2", a_data_o, 8'hA5);
    check("sw_cnt_c2",  a_count,  1);
    tick();
    check("sw_v_o_c3",  a_v_o,    1);
    check("sw_data_c3", a_data_o, 8'hA5);
    a_yumi = 1'b1; tick(); a_yumi = 1'b0;
    check("sw_empty_v", a_v_o,   0);
    check("sw_empty_c", a_count, 0);

    // Fill without dequeue: capacity is 5 words
    for (int i = 1; i <= 6; i++) begin
      a_v_i = 1'b1; a_data_i = 8'(i); #1;
      check("fill_w_v", a_w_v, (i <= 5) ? 1 : 0);
      if (i == 6) check("fill_ready", a_ready, 0);
      tick();
    end
    a_v_i = 1'b0;
    check("fill_count", a_count,  5);
    check("fill_head",  a_data_o, 1);
    for (int k = 1; k <= 5; k++) begin
      check("drain_v", a_v_o, 1);
      check("drain_d", a_data_o, k);
      a_yumi = a_v_o; tick(); a_yumi = 1'b0;
    end
    check("drain_empty", a_v_o,   0);
    check("drain_cnt",   a_count, 0);

    // Backpressure while the read is in flight
    a_v_i = 1'b1; a_data_i = 8'h3C; tick();
    a_data_i = 8'h4D; tick();
    a_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_v", a_v_o, 1);
      check("bp_hold_d", a_data_o, 8'h3C);
      tick();
    end
    check("bp_cnt", a_count, 2);
    a_yumi = 1'b1; tick(); a_yumi = 1'b0;
    check("bp_next_v", a_v_o, 1);
    check("bp_next_d", a_data_o, 8'h4D);
    a_yumi = 1'b1; tick(); a_yumi = 1'b0;
    check("bp_empty", a_v_o, 0);

    // Mid-stream reset with a read pending
    for (int i = 0; i < 4; i++) begin
      a_v_i = 1'b1; a_data_i = 8'(8'h60 + i); tick();
    end
    a_v_i = 1'b0;
    check("mr_cnt4", a_count, 4);
    a_yumi = 1'b1; tick(); a_yumi = 1'b0;
    check("mr_cnt3", a_count, 3);
    check("mr_pend", a_data_o, 8'h61);
    rst_n = 1'b0; #1;
    check("mr_v_o",  a_v_o,   0);
    check("mr_rdy",  a_ready, 0);
    check("mr_r_v",  a_r_v,   0);
    check("mr_cnt0", a_count, 0);
    tick();
    rst_n = 1'b1; tick();
    a_v_i = 1'b1; a_data_i = 8'h11; tick();
    a_v_i = 1'b0; tick(); tick();
    check("mr_new_v", a_v_o, 1);
    check("mr_new_d", a_data_o, 8'h11);
    check("mr_new_c", a_count, 1);
    a_yumi = 1'b1; tick(); a_yumi = 1'b0;
    check("mr_after_v", a_v_o, 0);
    check("mr_after_c", a_count, 0);

    // Streaming on the 3-deep instance; pointers must wrap 2 -> 0
    sent = 0; got = 0; wp = 0; rp = 0;
    for (int t = 0; t < 60 && got < 20; t++) begin
      b_yumi = b_v_o;
      if (b_yumi) begin
        if (exp_q.size() == 0) check("st_underflow", 1, 0);
        else begin
          exp_w = exp_q.pop_front();
          check("st_data", b_data_o, exp_w);
        end
        got++;
      end
      b_v_i = (sent < 20);
      b_data_i = 8'(sent);
      #1;
      if (t >= 2 && t < 20) check("st_count", b_count, 2);
      if (b_v_i) begin
        check("st_ready", b_ready, 1);
        check("st_w_addr", b_w_addr, wp);
        if (b_w_v) begin
          exp_q.push_back(b_data_i);
          sent++;
          wp = (wp == 2) ? 0 : wp + 1;
        end
      end
      if (b_r_v) begin
        check("st_r_addr", b_r_addr, rp);
        rp = (rp == 2) ? 0 : rp + 1;
      end
      tick();
    end
    b_v_i = 1'b0; b_yumi = 1'b0;
    check("st_got", got, 20);
    check("st_end_cnt", b_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
